detectfaces_sdiv_22s_6s_16_seq: RTL and testbench

DETECTFACES_SDIV_22S_6S_16_SEQ -- requirements
Module: detectfaces_sdiv_22s_6s_16_seq

---
 rtl/detectfaces_sdiv_22s_6s_16_seq.sv | 132 +++++++++++++
 tb/tb_detectfaces_sdiv_22s_6s_16_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/detectfaces_sdiv_22s_6s_16_seq.sv
// Sequential signed divider: 22-bit dividend / 6-bit divisor -> saturated unsigned 16-bit quotient.
// Restoring division on operand magnitudes; signs and clamping are applied in a single fix-up cycle.
module detectfaces_sdiv_22s_6s_16_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 22,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  dbz
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int CW = $clog2(din0_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(din0_WIDTH);

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [din0_WIDTH-1:0] a_reg;   // raw dividend, then |dividend|, then quotient magnitude
    logic [din1_WIDTH-1:0] b_reg;   // raw divisor, then |divisor|
    logic [din1_WIDTH:0]   r_reg;   // partial remainder
    logic                  sa;
    logic                  sb;

    logic [din1_WIDTH:0]   trial;
    logic                  ge;
    logic [din1_WIDTH:0]   diff;
    logic                  q_nz;
    logic                  q_neg;
    logic                  q_big;
    logic [din1_WIDTH-1:0] r_mag;

    always_comb begin
        trial = {r_reg[din1_WIDTH-1:0], a_reg[din0_WIDTH-1]};
        ge    = trial >= {1'b0, b_reg};
        diff  = trial - {1'b0, b_reg};
        q_nz  = |a_reg;
        q_neg = (sa ^ sb) && q_nz;
        q_big = |a_reg[din0_WIDTH-1:dout_WIDTH];
        r_mag = r_reg[din1_WIDTH-1:0];
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // cnt==0 in CALC is a magnitude-conversion cycle; iterations run on cnt 1..din0_WIDTH.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            r_reg <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            dout  <= '0;
            rem   <= '0;
            ovf   <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= din0;
                        b_reg <= din1;
                        sa    <= din0[din0_WIDTH-1];
                        sb    <= din1[din1_WIDTH-1];
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '0) begin
                        a_reg <= sa ? (~a_reg + 1'b1) : a_reg;
                        b_reg <= sb ? (~b_reg + 1'b1) : b_reg;
                        r_reg <= '0;
                    end else begin
                        r_reg <= ge ? diff : trial;
                        a_reg <= {a_reg[din0_WIDTH-2:0], ge};
                        if (cnt == LAST) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (b_reg == '0) begin
                        dout <= '1;
                        rem  <= '0;
                        ovf  <= 1'b0;
                        dbz  <= 1'b1;
                    end else begin
                        dbz <= 1'b0;
                        rem <= sa ? (~r_mag + 1'b1) : r_mag;
                        if (q_neg) begin
                            dout <= '0;
                            ovf  <= 1'b1;
                        end else if (q_big) begin
                            dout <= '1;
                            ovf  <= 1'b1;
                        end else begin
                            dout <= a_reg[dout_WIDTH-1:0];
                            ovf  <= 1'b0;
                        end
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_detectfaces_sdiv_22s_6s_16_seq.sv
// Self-checking bench for the sequential signed divider: directed corner cases plus random
// operands against an integer-arithmetic reference model.
module tb_detectfaces_sdiv_22s_6s_16_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [21:0] din0 = '0;
    logic [5:0]  din1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] dout;
    logic [5:0]  rem;
    logic        ovf;
    logic        dbz;

    int unsigned checks = 0;
    int unsigned passes = 0;

    detectfaces_sdiv_22s_6s_16_seq #(
        .ID(1), .din0_WIDTH(22), .din1_WIDTH(6), .dout_WIDTH(16)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .rem(rem), .ovf(ovf), .dbz(dbz)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // Reference: truncating integer division, remainder follows the dividend's sign.
    task automatic model(input int a, input int b, output logic [15:0] ed, output logic [5:0] er,
                         output logic eo, output logic ez);
        longint q, r;
        if (b == 0) begin
            ed = 16'hFFFF; er = '0; eo = 1'b0; ez = 1'b1;
        end else begin
            q = longint'(a) / longint'(b);
            r = longint'(a) - q * longint'(b);
            ez = 1'b0;
            if (q < 0) begin
                ed = '0; eo = 1'b1;
            end else if (q > 65535) begin
                ed = 16'hFFFF; eo = 1'b1;
            end else begin
                ed = q[15:0]; eo = 1'b0;
            end
            er = r[5:0];
        end
    endtask

    // Issue one operation, check latency and result; optionally stall in DONE for 'hold' cycles.
    task automatic run_op(input int a, input int b, input int hold);
        logic [15:0] ed;
        logic [5:0]  er;
        logic        eo, ez;
        int          n;
        logic [15:0] d0;
        logic [5:0]  r0;
        model(a, b, ed, er, eo, ez);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge ap_clk); n++; @(negedge ap_clk);
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        din0 = 22'(a);
        din1 = 6'(b);
        @(posedge ap_clk);
        @(negedge ap_clk);
        // keep presenting junk while busy; it must be ignored
        din0 = 22'($urandom);
        din1 = 6'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge ap_clk); n++; @(negedge ap_clk);
        end
        in_valid = 1'b0;
        check("latency", 32'(n), 32'd24);
        check("dout", 32'(dout), 32'(ed));
        check("rem", 32'(rem), 32'(er));
        check("ovf", 32'(ovf), 32'(eo));
        check("dbz", 32'(dbz), 32'(ez));
        d0 = dout;
        r0 = rem;
        for (int i = 0; i < hold; i++) begin
            @(posedge ap_clk); @(negedge ap_clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_dout", 32'(dout), 32'(d0));
            check("hold_rem", 32'(rem), 32'(r0));
        end
        out_ready = 1'b1;
        @(posedge ap_clk); @(negedge ap_clk);
        out_ready = 1'b0;
        check("post_done_in_ready", 32'(in_ready), 32'd1);
        check("post_done_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int a, b, n;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);
        @(negedge ap_clk); @(negedge ap_clk);
        ap_rst = 1'b0;

        run_op(-3000, -3, 0);
        run_op(1003, 5, 0);
        run_op(-7, 2, 0);
        run_op(2097151, 1, 0);
        run_op(-2097152, -32, 10);
        run_op(1234, 0, 0);
        run_op(-2097152, 31, 0);
        run_op(5, -32, 0);

        // Reset during CALC discards the operation.
        in_valid = 1'b1; din0 = 22'(1003); din1 = 6'(5);
        @(posedge ap_clk); @(negedge ap_clk);
        in_valid = 1'b0;
        repeat (10) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b1;
        #1;
        check("midcalc_rst_valid", 32'(out_valid), 32'd0);
        check("midcalc_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge ap_clk); @(negedge ap_clk);
            if (out_valid) n++;
        end
        check("no_result_after_rst", 32'(n), 32'd0);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        run_op(1003, 5, 0);

        // Asynchronous reset while a result is held in DONE clears outputs without a clock edge.
        in_valid = 1'b1; din0 = 22'(-3000); din1 = 6'(-3);
        @(posedge ap_clk); @(negedge ap_clk);
        in_valid = 1'b0;
        repeat (24) @(posedge ap_clk);
        @(negedge ap_clk);
        check("done_before_rst", 32'(out_valid), 32'd1);
        #2 ap_rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_dout", 32'(dout), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        for (int k = 0; k < 20; k++) begin
            a = int'($urandom_range(0, 4194303)) - 2097152;
            b = int'($urandom_range(0, 63)) - 32;
            if (k % 3 == 0) a = int'($urandom_range(0, 2000)) - 1000;
            run_op(a, b, (k == 5) ? 3 : 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
